// File: rtl/mem_burst_master.sv
// Burst sequencer that owns the data_memory port: N word/byte reads or writes
// from a base address, with address stepping and one-cycle read return.
module mem_burst_master #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int COUNT_WIDTH   = 10
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     op_write,
   input  logic                     byte_mode,
   input  logic [ADDRESS_WIDTH-1:0] base_addr,
   input  logic [COUNT_WIDTH-1:0]   count,
   output logic                     busy,
   output logic                     done,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [DATA_WIDTH-1:0]    rd_data,
   output logic                     rd_valid,
   output logic [ADDRESS_WIDTH-1:0] address,
   output logic [DATA_WIDTH-1:0]    write_data,
   output logic                     we,
   output logic                     re,
   output logic                     be,
   input  logic [DATA_WIDTH-1:0]    read_data
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_READ  = 3'd1;
   localparam logic [2:0] S_DRAIN = 3'd2;
   localparam logic [2:0] S_WRITE = 3'd3;
   localparam logic [2:0] S_DONE  = 3'd4;

   logic [2:0]               state;
   logic [ADDRESS_WIDTH-1:0] cur_addr;
   logic [COUNT_WIDTH-1:0]   remaining;
   logic                     mode_byte;
   logic                     rd_pend;
   logic                     rd_pend_byte;
   logic [ADDRESS_WIDTH-1:0] stride;
   logic                     issue_rd;
   logic                     issue_wr;
   logic                     strobe;
   logic                     last_beat;

   always_comb begin
      stride    = mode_byte ? ADDRESS_WIDTH'(1) : ADDRESS_WIDTH'(4);
      issue_rd  = (state == S_READ);
      wr_ready  = (state == S_WRITE);
      issue_wr  = wr_ready && wr_valid;
      strobe    = issue_rd || issue_wr;
      last_beat = (remaining == COUNT_WIDTH'(1));
   end

   // Memory-side outputs are combinational so a write beat reaches memory in
   // the same cycle it is accepted; they are forced to zero when idle.
   always_comb begin
      re         = issue_rd;
      we         = issue_wr;
      address    = strobe ? cur_addr : '0;
      be         = strobe ? mode_byte : 1'b0;
      write_data = '0;
      if (issue_wr)
         write_data = mode_byte ? {{(DATA_WIDTH-8){1'b0}}, wr_data[7:0]} : wr_data;
   end

   always_comb begin
      busy     = (state != S_IDLE);
      done     = (state == S_DRAIN) || (state == S_DONE);
      rd_valid = rd_pend;
      rd_data  = '0;
      if (rd_pend)
         rd_data = rd_pend_byte ? {{(DATA_WIDTH-8){1'b0}}, read_data[7:0]} : read_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= S_IDLE;
         cur_addr     <= '0;
         remaining    <= '0;
         mode_byte    <= 1'b0;
         rd_pend      <= 1'b0;
         rd_pend_byte <= 1'b0;
      end else begin
         rd_pend      <= issue_rd;
         rd_pend_byte <= mode_byte;
         case (state)
            S_IDLE: begin
               if (start) begin
                  mode_byte <= byte_mode;
                  cur_addr  <= byte_mode ? base_addr : {base_addr[ADDRESS_WIDTH-1:2], 2'b00};
                  remaining <= count;
                  if (count == '0)
                     state <= S_DONE;
                  else
                     state <= op_write ? S_WRITE : S_READ;
               end
            end
            S_READ: begin
               cur_addr  <= cur_addr + stride;
               remaining <= remaining - COUNT_WIDTH'(1);
               if (last_beat)
                  state <= S_DRAIN;
            end
            S_DRAIN: state <= S_IDLE;
            S_WRITE: begin
               if (issue_wr) begin
                  cur_addr  <= cur_addr + stride;
                  remaining <= remaining - COUNT_WIDTH'(1);
                  if (last_beat)
                     state <= S_DONE;
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_burst_master.sv
// Self-checking bench for mem_burst_master: directed vector table, random
// commands against a cycle-level burst model, and a mid-burst reset sequence.
module tb_mem_burst_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic        op_write;
   logic        byte_mode;
   logic [31:0] base_addr;
   logic [9:0]  count;
   logic        busy;
   logic        done;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic [31:0] address;
   logic [31:0] write_data;
   logic        we;
   logic        re;
   logic        be;
   logic [31:0] read_data;

   int errors = 0;
   int checks = 0;

   logic [7:0] mem [256];

   mem_burst_master #(
      .DATA_WIDTH(32),
      .ADDRESS_WIDTH(32),
      .COUNT_WIDTH(10)
   ) dut (
      .clk(clk), .rst(rst), .start(start), .op_write(op_write),
      .byte_mode(byte_mode), .base_addr(base_addr), .count(count),
      .busy(busy), .done(done), .wr_data(wr_data), .wr_valid(wr_valid),
      .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .address(address), .write_data(write_data), .we(we), .re(re), .be(be),
      .read_data(read_data)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] bidx(input logic [31:0] a, input int unsigned o);
      return 8'(a[7:0] + 8'(o));
   endfunction

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {mem[bidx(a, 3)], mem[bidx(a, 2)], mem[bidx(a, 1)], mem[bidx(a, 0)]};
   endfunction

   // Byte-addressed memory (low 8 address bits), returns the word at the
   // byte address one cycle after re; reset reloads mem[i] = i.
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) mem[i] <= 8'(i);
         read_data <= '0;
      end else begin
         if (we) begin
            if (be) mem[address[7:0]] <= write_data[7:0];
            else for (int i = 0; i < 4; i++) mem[bidx(address, i)] <= write_data[8*i +: 8];
         end
         if (re) read_data <= mem_word(address);
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_busy"},  32'(busy), 0);
      chk({nm, "_done"},  32'(done), 0);
      chk({nm, "_rdy"},   32'(wr_ready), 0);
      chk({nm, "_rv"},    32'(rd_valid), 0);
      chk({nm, "_rdata"}, rd_data, 0);
      chk({nm, "_addr"},  address, 0);
      chk({nm, "_wdata"}, write_data, 0);
      chk({nm, "_we"},    32'(we), 0);
      chk({nm, "_re"},    32'(re), 0);
      chk({nm, "_be"},    32'(be), 0);
   endtask

   // vmode: 0 = wr_valid always 1, 1 = vpat bits for first 8 cycles, 2 = random
   task automatic run_cmd(input logic opw, input logic bm, input logic [31:0] base,
                          input logic [9:0] cnt, input logic [31:0] wd, input int vmode,
                          input logic [7:0] vpat, output logic [31:0] a0, output logic [31:0] d0);
      logic [31:0] ea, stride, exp_addr, exp_wdata, exp_rdata;
      logic exp_re, exp_we, exp_rv, exp_done, exp_rdy, vld, fin, got_a, got_d;
      int unsigned k;
      logic [31:0] rdq[$];
      a0 = '0; d0 = '0; got_a = 0; got_d = 0; fin = 0; k = 0;
      @(posedge clk); #1;
      start = 1; op_write = opw; byte_mode = bm; base_addr = base; count = cnt;
      wr_valid = 0; wr_data = wd;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_rv", 32'(rd_valid), 0);
      @(posedge clk); #1;
      ea = bm ? base : {base[31:2], 2'b00};
      stride = bm ? 32'd1 : 32'd4;
      for (int c = 1; c <= 200 && !fin; c++) begin
         start = 1'($urandom); op_write = 1'($urandom); byte_mode = 1'($urandom);
         base_addr = $urandom; count = 10'($urandom);
         case (vmode)
            0: vld = 1'b1;
            1: vld = (c <= 8) ? vpat[c-1] : 1'b1;
            default: vld = (c > 100) || ($urandom_range(0, 2) != 0);
         endcase
         wr_valid = vld;
         wr_data  = (vmode == 2) ? $urandom : wd;
         exp_re   = !opw && (c <= int'(cnt));
         exp_rv   = !opw && (c >= 2) && (c <= int'(cnt) + 1);
         exp_rdy  = opw && (k < cnt);
         exp_we   = exp_rdy && vld;
         exp_done = opw ? (k == cnt) : (c == ((cnt == 0) ? 1 : int'(cnt) + 1));
         exp_addr = exp_re ? ea + 32'(c - 1) * stride : exp_we ? ea + 32'(k) * stride : 32'd0;
         exp_wdata = exp_we ? (bm ? {24'h0, wr_data[7:0]} : wr_data) : 32'd0;
         @(negedge clk);
         chk("busy",  32'(busy), 1);
         chk("done",  32'(done), 32'(exp_done));
         chk("re",    32'(re), 32'(exp_re));
         chk("we",    32'(we), 32'(exp_we));
         chk("rdy",   32'(wr_ready), 32'(exp_rdy));
         chk("addr",  address, exp_addr);
         chk("wdata", write_data, exp_wdata);
         chk("be",    32'(be), 32'((exp_re || exp_we) && bm));
         chk("rv",    32'(rd_valid), 32'(exp_rv));
         if ((exp_re || exp_we) && !got_a) begin a0 = address; got_a = 1; end
         if (exp_we && !got_d) begin d0 = write_data; got_d = 1; end
         if (exp_rv) begin
            exp_rdata = (rdq.size() > 0) ? rdq.pop_front() : 32'd0;
            chk("rdata", rd_data, exp_rdata);
            if (!got_d) begin d0 = rd_data; got_d = 1; end
         end
         if (exp_re) rdq.push_back(bm ? {24'h0, mem[exp_addr[7:0]]} : mem_word(exp_addr));
         if (exp_we) k++;
         fin = exp_done;
         if (!fin) begin @(posedge clk); #1; end
      end
      if (!fin) chk("cmd_timeout", 0, 1);
      start = 0; wr_valid = 0;
   endtask

   typedef struct {
      logic        opw;
      logic        bm;
      logic [31:0] base;
      logic [9:0]  cnt;
      logic [31:0] wd;
      int          vmode;
      logic [7:0]  vpat;
      logic        chk0;
      logic [31:0] exp_a0;
      logic [31:0] exp_d0;
   } vec_t;

   vec_t vecs[9];

   initial begin
      logic [31:0] a0, d0;
      vecs[0] = '{1'b0, 1'b0, 32'h0000_0000, 10'd10, 32'h0, 0, 8'h00, 1'b1, 32'h0000_0000, 32'h0302_0100};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_001B, 10'd1,  32'hB6A8_4325, 0, 8'h00, 1'b1, 32'h0000_0018, 32'hB6A8_4325};
      vecs[2] = '{1'b0, 1'b0, 32'h0000_0018, 10'd1,  32'h0, 0, 8'h00, 1'b1, 32'h0000_0018, 32'hB6A8_4325};
      vecs[3] = '{1'b1, 1'b1, 32'h0000_0019, 10'd1,  32'hFFFF_FF74, 0, 8'h00, 1'b1, 32'h0000_0019, 32'h0000_0074};
      vecs[4] = '{1'b0, 1'b1, 32'h0000_0019, 10'd1,  32'h0, 0, 8'h00, 1'b1, 32'h0000_0019, 32'h0000_0074};
      vecs[5] = '{1'b1, 1'b0, 32'h0000_0040, 10'd3,  32'hCAFE_0001, 1, 8'b0001_1001, 1'b1, 32'h0000_0040, 32'hCAFE_0001};
      vecs[6] = '{1'b0, 1'b0, 32'hFFFF_FFFC, 10'd2,  32'h0, 0, 8'h00, 1'b1, 32'hFFFF_FFFC, 32'hFFFE_FDFC};
      vecs[7] = '{1'b0, 1'b0, 32'h0000_0080, 10'd0,  32'h0, 0, 8'h00, 1'b0, 32'h0, 32'h0};
      vecs[8] = '{1'b1, 1'b1, 32'h0000_0081, 10'd0,  32'h0, 0, 8'h00, 1'b0, 32'h0, 32'h0};

      rst = 1; start = 0; op_write = 0; byte_mode = 0; base_addr = '0; count = '0;
      wr_data = '0; wr_valid = 0;
      repeat (3) @(posedge clk);
      #1 chk_all_zero("reset");
      rst = 0;

      for (int i = 0; i < 9; i++) begin
         run_cmd(vecs[i].opw, vecs[i].bm, vecs[i].base, vecs[i].cnt, vecs[i].wd,
                 vecs[i].vmode, vecs[i].vpat, a0, d0);
         if (vecs[i].chk0) begin
            chk($sformatf("vec%0d_addr0", i), a0, vecs[i].exp_a0);
            chk($sformatf("vec%0d_data0", i), d0, vecs[i].exp_d0);
         end
      end

      for (int i = 0; i < 30; i++)
         run_cmd(1'($urandom), 1'($urandom), $urandom, 10'($urandom_range(0, 12)),
                 32'h0, 2, 8'h00, a0, d0);

      // Reset asserted in cycle 3 of an 8-beat read aborts it silently.
      @(posedge clk); #1;
      start = 1; op_write = 0; byte_mode = 0; base_addr = 32'h40; count = 10'd8;
      @(posedge clk); #1 start = 0;
      @(posedge clk); #1;
      chk("rst_pre_busy", 32'(busy), 1);
      chk("rst_pre_rv", 32'(rd_valid), 1);
      @(posedge clk); #1 rst = 1;
      #1 chk_all_zero("rst_mid");
      @(posedge clk); #1 start = 1;
      @(posedge clk); #1 rst = 0; start = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("post_rst_rv", 32'(rd_valid), 0);
         chk("post_rst_done", 32'(done), 0);
         chk("post_rst_busy", 32'(busy), 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_burst_master.md
# mem_burst_master

Sequencing master that drives the `data_memory` port (address / write_data / we / re / be / read_data) on behalf of a streaming client. It runs one command at a time: a burst of N word or byte reads, or N word or byte writes, starting at a base address. It handles address stepping and the one-cycle read return. It sits between the datapath's vector/DMA-style units and `data_memory`, and owns that memory port while busy.

## Interface
Parameters:
- `DATA_WIDTH`, 32, memory data width.
- `ADDRESS_WIDTH`, 32, byte address width.
- `COUNT_WIDTH`, 10, width of the burst length field (max 1023 beats).

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  command strobe, sampled in IDLE only.
- `op_write`  in  1  0 = read burst, 1 = write burst.
- `byte_mode`  in  1  0 = word beats (stride 4), 1 = byte beats (stride 1).
- `base_addr`  in  ADDRESS_WIDTH  first byte address.
- `count`  in  COUNT_WIDTH  number of beats.
- `busy`  out  1  command in progress.
- `done`  out  1  one-cycle completion pulse.
- `wr_data`  in  DATA_WIDTH  write beat data.
- `wr_valid`  in  1  write beat offered.
- `wr_ready`  out  1  write beat accepted when high with `wr_valid`.
- `rd_data`  out  DATA_WIDTH  read beat data.
- `rd_valid`  out  1  read beat present; no backpressure, consumer must take it.
- `address`  out  ADDRESS_WIDTH  to memory.
- `write_data`  out  DATA_WIDTH  to memory.
- `we`, `re`, `be`  out  1 each  to memory; `be`=1 selects byte access.
- `read_data`  in  DATA_WIDTH  from memory, valid the cycle after `re`.

## Operation
- States: IDLE, READ, DRAIN, WRITE, DONE.
- IDLE:
  - `start` latches `op_write`, `byte_mode`, `count`, and the address. In word mode the address is latched with bits [1:0] forced to 00.
  - Next state: READ or WRITE, or DONE if `count`==0.
- READ:
  - Asserts `re` every cycle with the current address and `be`=`byte_mode`.
  - After each issue, the address steps by 4 (word) or 1 (byte) and the remaining count decrements.
  - After the Nth issue, goes to DRAIN.
- DRAIN: one cycle for the last return, then IDLE.
  - `done` is asserted in DRAIN, coincident with the last `rd_valid`.
- Read return:
  - `rd_valid` is high the cycle after each `re` cycle.
  - `rd_data` = `read_data` in word mode; {zeros, `read_data`[7:0]} in byte mode.
- WRITE:
  - `wr_ready`=1. On `wr_valid`&&`wr_ready`, in the same cycle: `we`=1, `address`=current address, `be`=`byte_mode`.
  - `write_data` = `wr_data` in word mode; {zeros, `wr_data`[7:0]} in byte mode.
  - Then step the address and decrement the count. Stalls with no memory strobe while `wr_valid`=0.
  - After the Nth beat, goes to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `busy`=1 in every state except IDLE.
- `start` while busy is ignored; the command fields are don't-care after latch.
- `re` and `we` are never high together. `address`, `write_data` and `be` are 0 whenever neither `re` nor `we` is asserted.
- Address arithmetic is modulo 2^ADDRESS_WIDTH; wrap-around is silent.

## Timing
- Reset:
  - State returns to IDLE.
  - All outputs go to 0: `busy`, `done`, `wr_ready`, `rd_valid`, `rd_data`, `address`, `write_data`, `we`, `re`, `be`.
  - Reset mid-burst aborts the command, discards any in-flight read return, and produces no `done`.
- Read burst of N (start sampled at edge 0):
  - `re` on cycles 1..N.
  - `rd_valid` on cycles 2..N+1.
  - `done` on cycle N+1; `busy` on cycles 1..N+1; IDLE at cycle N+2.
  - Throughput: 1 beat/cycle.
- Write burst of N with `wr_valid` held high:
  - `we` on cycles 1..N.
  - `done` on cycle N+1.
  - Each stalled cycle adds one cycle.
- `count`==0: `busy` and `done` on cycle 1, with no memory strobes.
- A new `start` is accepted in the IDLE cycle right after `done`, i.e. the earliest back-to-back command.
- Memory assumption: synchronous write; registered read with 1-cycle latency.

## Test plan
- Read, word mode, `base_addr`=0x00, `count`=10 -> `re` addresses 0x00, 0x04 … 0x24 on consecutive cycles. `rd_valid`×10 returns the preloaded words in order. `done` coincides with the 10th beat.
- Write, word mode, `base_addr`=0x1B, `count`=1, `wr_data`=0xB6A84325 -> `we` at 0x18 with data 0xB6A84325. A following 1-beat word read at 0x18 returns 0xB6A84325.
- Write, byte mode, `base_addr`=0x19, `count`=1, `wr_data`=0xFFFFFF74 -> `we`, `be`=1, address 0x19, `write_data`=0x00000074. A byte read at 0x19 returns `rd_data`=0x00000074.
- Write, word mode, `count`=3, with `wr_valid` toggling 1,0,0,1,1 -> exactly 3 `we` pulses, only on the valid cycles, at addresses +0/+4/+8. `done` follows the cycle after the third beat.
- Read, word mode, `base_addr`=0xFFFFFFFC, `count`=2 -> addresses 0xFFFFFFFC then 0x00000000. Separately, `count`=0 -> single `done`, no `re`/`we`.
- Assert `rst` on cycle 3 of an 8-beat read -> all outputs 0 the same cycle, no `rd_valid` or `done` after reset release. `start` ignored while busy.
